commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Synthesizable retirement-trace capture unit for the RISC-V core: samples one commit record per cycle (pc, instr, rd write, memory access, stall/flush status), classifies it, and buffers it in a parametrised FIFO.
- Records drain through a valid/ready port to a trace sink (UART/debug DMA), replacing simulation-only log printing for on-silicon and long runs.
- Adds filtering, sequence numbering, overflow policy and drop accounting.

Parameters:
- XLEN, 32, datapath width of pc/instr/data/address fields.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- SEQ_W, 8, width of per-record sequence number (wraps).
- DROP_W, 16, width of saturating drop counter.
- DROP_OLDEST, 0, overflow policy: 0 = discard incoming record, 1 = overwrite oldest entry.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- commit_valid_i  in  1  commit record present this cycle
- pc_i  in  XLEN  committed pc
- instr_i  in  XLEN  committed instruction word
- reg_addr_i  in  5  destination register (0 = no write)
- reg_data_i  in  XLEN  register write data
- mem_addr_i  in  XLEN  load/store address
- mem_data_i  in  XLEN  store data
- stall_i  in  1  pipeline stall status
- flushD_i  in  1  decode flush
- flushE_i  in  1  execute flush
- filter_en_i  in  1  when 1, records with nonzero flags are not captured
- clear_i  in  1  synchronous clear of FIFO, counters and sticky flag
- rec_valid_o  out  1  head record available
- rec_ready_i  in  1  sink accepts head record
- rec_pc_o  out  XLEN  head pc
- rec_instr_o  out  XLEN  head instr
- rec_kind_o  out  3  head record kind
- rec_rd_o  out  5  head rd
- rec_data_o  out  XLEN  head data (reg data or masked store data)
- rec_addr_o  out  XLEN  head memory address (0 when not memory kind)
- rec_flags_o  out  2  head flags: [0] stall, [1] flush
- rec_seq_o  out  SEQ_W  head sequence number
- level_o  out  $clog2(DEPTH)+1  occupancy
- drop_cnt_o  out  DROP_W  records lost to overflow, saturating
- overflow_o  out  1  sticky: at least one drop since reset/clear

Behaviour:
- Reset (rstn_i low, async): FIFO empty, level_o 0, rec_valid_o 0, all rec_* 0, seq counter 0, drop_cnt_o 0, overflow_o 0.
- Classification (combinational on inputs, registered into FIFO), priority order: opcode 0100011 -> funct3 000/001/010 = STORE_B(3)/STORE_H(4)/STORE_W(5), other funct3 = NONE(0); opcode 0000011 -> LOAD(2), data = reg_data_i; else rd != 0 -> REG(1); rd == 0 -> stall_i STALL(6), else flushD_i|flushE_i FLUSH(7), else NONE(0).
- Store data zero-extended from [7:0]/[15:0]/full; rec_addr = mem_addr_i for LOAD/STORE_*, else 0; rec_rd = 0 for stores.
- flags[0] = stall_i; flags[1] = (flushD_i|flushE_i) & ~stall_i.
- Capture: commit_valid_i & ~(filter_en_i & flags!=0). Every captured commit consumes a seq number (seq++ mod 2^SEQ_W), including dropped ones, so sink sees gaps.
- FIFO: first-word-fall-through; rec_valid_o = level_o != 0; pop when rec_valid_o & rec_ready_i; capture-to-rec_valid_o latency 1 cycle when empty.
- Push and pop same cycle: always accepted, level unchanged, including when full.
- Full, push, no pop: DROP_OLDEST=0 -> incoming discarded; DROP_OLDEST=1 -> oldest entry discarded, incoming written, head advances (head fields may change while rec_valid_o high and rec_ready_i low; documented exception to stability). Either case: drop_cnt_o +1 saturating at all-ones, overflow_o set.
- Empty and pop not possible (rec_valid_o 0).
- Pointers wrap modulo DEPTH; level_o reaches DEPTH exactly.
- clear_i: priority over push/pop same cycle; next cycle FIFO empty, seq 0, drop_cnt_o 0, overflow_o 0; the commit in the clear cycle is not captured.
- Reset mid-operation: all state returns to reset values immediately; in-flight records lost.

Test Plan:
- Reset, push ADDI x5 (rd=5, data 0x0000000A, pc 0x80000000), rec_ready_i=1 -> next cycle rec_valid_o=1, kind 1, rd 5, data 0x0000000A, seq 0; popped, level 0.
- SB instr 0x00510023, mem_data 0x12345678, addr 0x100 -> kind 3, data 0x00000078, addr 0x100; SH -> kind 4, data 0x00005678.
- rd=0 with stall_i=1, filter_en_i=0 -> kind 6, flags 01; same with filter_en_i=1 -> nothing captured, seq not incremented.
- DROP_OLDEST=0, DEPTH=8, rec_ready_i=0, 10 commits seq 0..9 -> level 8, drop_cnt 2, overflow 1, drain yields seq 0..7.
- DROP_OLDEST=1, same stimulus -> drop_cnt 2, drain yields seq 2..9; full with rec_ready_i=1 and push -> no drop, level stays 8.
- clear_i asserted with concurrent push while full -> next cycle level 0, drop_cnt 0, overflow 0, rec_valid_o 0; next capture gets seq 0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Retirement-trace capture: classifies one commit record per cycle and buffers it
// in a first-word-fall-through FIFO drained over a valid/ready port.
module commit_trace_buffer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SEQ_W       = 8,
    parameter int unsigned DROP_W      = 16,
    parameter int unsigned DROP_OLDEST = 0
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        commit_valid_i,
    input  logic [XLEN-1:0]             pc_i,
    input  logic [XLEN-1:0]             instr_i,
    input  logic [4:0]                  reg_addr_i,
    input  logic [XLEN-1:0]             reg_data_i,
    input  logic [XLEN-1:0]             mem_addr_i,
    input  logic [XLEN-1:0]             mem_data_i,
    input  logic                        stall_i,
    input  logic                        flushD_i,
    input  logic                        flushE_i,
    input  logic                        filter_en_i,
    input  logic                        clear_i,
    output logic                        rec_valid_o,
    input  logic                        rec_ready_i,
    output logic [XLEN-1:0]             rec_pc_o,
    output logic [XLEN-1:0]             rec_instr_o,
    output logic [2:0]                  rec_kind_o,
    output logic [4:0]                  rec_rd_o,
    output logic [XLEN-1:0]             rec_data_o,
    output logic [XLEN-1:0]             rec_addr_o,
    output logic [1:0]                  rec_flags_o,
    output logic [SEQ_W-1:0]            rec_seq_o,
    output logic [$clog2(DEPTH):0]      level_o,
    output logic [DROP_W-1:0]           drop_cnt_o,
    output logic                        overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [2:0] KIND_NONE    = 3'd0;
    localparam logic [2:0] KIND_REG     = 3'd1;
    localparam logic [2:0] KIND_LOAD    = 3'd2;
    localparam logic [2:0] KIND_STORE_B = 3'd3;
    localparam logic [2:0] KIND_STORE_H = 3'd4;
    localparam logic [2:0] KIND_STORE_W = 3'd5;
    localparam logic [2:0] KIND_STALL   = 3'd6;
    localparam logic [2:0] KIND_FLUSH   = 3'd7;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  data;
        logic [XLEN-1:0]  addr;
        logic [2:0]       kind;
        logic [4:0]       rd;
        logic [1:0]       flags;
        logic [SEQ_W-1:0] seq;
    } rec_t;

    rec_t              mem [DEPTH];
    rec_t              in_rec;
    rec_t              head;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [DROP_W-1:0] drop_q;
    logic              ovf_q;
    logic [1:0]        flags;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr_en;

    assign flags = {(flushD_i | flushE_i) & ~stall_i, stall_i};
    assign push  = commit_valid_i & ~(filter_en_i & (flags != 2'b00)) & ~clear_i;
    assign pop   = rec_valid_o & rec_ready_i;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign wr_en = push & (pop | ~full | (DROP_OLDEST != 0));

    // Commit classification in priority order: store, load, reg write, stall, flush
    always_comb begin
        in_rec       = '0;
        in_rec.pc    = pc_i;
        in_rec.instr = instr_i;
        in_rec.flags = flags;
        in_rec.seq   = seq_q;
        if (instr_i[6:0] == OPC_STORE) begin
            case (instr_i[14:12])
                3'b000: begin
                    in_rec.kind = KIND_STORE_B;
                    in_rec.data = XLEN'(mem_data_i[7:0]);
                    in_rec.addr = mem_addr_i;
                end
                3'b001: begin
                    in_rec.kind = KIND_STORE_H;
                    in_rec.data = XLEN'(mem_data_i[15:0]);
                    in_rec.addr = mem_addr_i;
                end
                3'b010: begin
                    in_rec.kind = KIND_STORE_W;
                    in_rec.data = mem_data_i;
                    in_rec.addr = mem_addr_i;
                end
                default: in_rec.kind = KIND_NONE;
            endcase
        end else if (instr_i[6:0] == OPC_LOAD) begin
            in_rec.kind = KIND_LOAD;
            in_rec.rd   = reg_addr_i;
            in_rec.data = reg_data_i;
            in_rec.addr = mem_addr_i;
        end else if (reg_addr_i != 5'd0) begin
            in_rec.kind = KIND_REG;
            in_rec.rd   = reg_addr_i;
            in_rec.data = reg_data_i;
        end else if (stall_i) begin
            in_rec.kind = KIND_STALL;
        end else if (flushD_i | flushE_i) begin
            in_rec.kind = KIND_FLUSH;
        end else begin
            in_rec.kind = KIND_NONE;
        end
    end

    // FIFO pointers, occupancy, sequence and drop accounting
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (push && pop) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                level_q  <= level_q + LVL_W'(1);
            end else if (push) begin
                // Full without pop: overwrite-oldest advances both pointers together
                if (DROP_OLDEST != 0) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                if (drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
                ovf_q <= 1'b1;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                level_q  <= level_q - LVL_W'(1);
            end
        end
    end

    // Record storage; contents are only observed through the occupancy-gated head
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= in_rec;
        end
    end

    assign head        = mem[rd_ptr_q];
    assign rec_valid_o = (level_q != '0);
    assign rec_pc_o    = rec_valid_o ? head.pc    : '0;
    assign rec_instr_o = rec_valid_o ? head.instr : '0;
    assign rec_kind_o  = rec_valid_o ? head.kind  : '0;
    assign rec_rd_o    = rec_valid_o ? head.rd    : '0;
    assign rec_data_o  = rec_valid_o ? head.data  : '0;
    assign rec_addr_o  = rec_valid_o ? head.addr  : '0;
    assign rec_flags_o = rec_valid_o ? head.flags : '0;
    assign rec_seq_o   = rec_valid_o ? head.seq   : '0;
    assign level_o     = level_q;
    assign drop_cnt_o  = drop_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench for commit_trace_buffer: both overflow policies run side by side
// against a queue-based reference model.
module tb_commit_trace_buffer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] addr;
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [1:0]  flags;
        logic [7:0]  seq;
    } mrec_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        commit_valid_i;
    logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
    logic [4:0]  reg_addr_i;
    logic        stall_i, flushD_i, flushE_i, filter_en_i, clear_i, rec_ready_i;

    logic        rv   [2];
    logic [31:0] rpc  [2];
    logic [31:0] rins [2];
    logic [2:0]  rknd [2];
    logic [4:0]  rrd  [2];
    logic [31:0] rdat [2];
    logic [31:0] radr [2];
    logic [1:0]  rflg [2];
    logic [7:0]  rseq [2];
    logic [3:0]  lvl  [2];
    logic [15:0] drp  [2];
    logic        ovf  [2];

    mrec_t       mq    [2][$];
    logic [7:0]  mseq  [2];
    logic [15:0] mdrop [2];
    logic        movf  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        commit_trace_buffer #(
            .XLEN(XLEN), .DEPTH(DEPTH), .SEQ_W(8), .DROP_W(16), .DROP_OLDEST(g)
        ) u_dut (
            .clk_i(clk_i), .rstn_i(rstn_i), .commit_valid_i(commit_valid_i),
            .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i),
            .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
            .stall_i(stall_i), .flushD_i(flushD_i), .flushE_i(flushE_i),
            .filter_en_i(filter_en_i), .clear_i(clear_i),
            .rec_valid_o(rv[g]), .rec_ready_i(rec_ready_i),
            .rec_pc_o(rpc[g]), .rec_instr_o(rins[g]), .rec_kind_o(rknd[g]),
            .rec_rd_o(rrd[g]), .rec_data_o(rdat[g]), .rec_addr_o(radr[g]),
            .rec_flags_o(rflg[g]), .rec_seq_o(rseq[g]), .level_o(lvl[g]),
            .drop_cnt_o(drp[g]), .overflow_o(ovf[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected record for the commit currently on the inputs
    function automatic mrec_t model_rec();
        mrec_t r;
        r          = '0;
        r.pc       = pc_i;
        r.instr    = instr_i;
        r.flags[0] = stall_i;
        r.flags[1] = (flushD_i | flushE_i) & ~stall_i;
        if (instr_i[6:0] == 7'b0100011) begin
            if (instr_i[14:12] == 3'd0) begin
                r.kind = 3'd3; r.data = mem_data_i & 32'h0000_00FF; r.addr = mem_addr_i;
            end else if (instr_i[14:12] == 3'd1) begin
                r.kind = 3'd4; r.data = mem_data_i & 32'h0000_FFFF; r.addr = mem_addr_i;
            end else if (instr_i[14:12] == 3'd2) begin
                r.kind = 3'd5; r.data = mem_data_i; r.addr = mem_addr_i;
            end
        end else if (instr_i[6:0] == 7'b0000011) begin
            r.kind = 3'd2; r.rd = reg_addr_i; r.data = reg_data_i; r.addr = mem_addr_i;
        end else if (reg_addr_i != 5'd0) begin
            r.kind = 3'd1; r.rd = reg_addr_i; r.data = reg_data_i;
        end else if (stall_i) begin
            r.kind = 3'd6;
        end else if (flushD_i | flushE_i) begin
            r.kind = 3'd7;
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            mq[p].delete();
            mseq[p]  = 8'd0;
            mdrop[p] = 16'd0;
            movf[p]  = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        mrec_t r;
        bit    cap;
        bit    pop;
        r   = model_rec();
        cap = commit_valid_i && !(filter_en_i && r.flags != 2'b00);
        if (clear_i) begin
            model_clear();
        end else begin
            for (int p = 0; p < 2; p++) begin
                pop   = (mq[p].size() != 0) && rec_ready_i;
                r.seq = mseq[p];
                if (cap && pop) begin
                    void'(mq[p].pop_front());
                    mq[p].push_back(r);
                end else if (cap) begin
                    if (mq[p].size() < DEPTH) begin
                        mq[p].push_back(r);
                    end else begin
                        if (mdrop[p] != 16'hFFFF) mdrop[p] = mdrop[p] + 16'd1;
                        movf[p] = 1'b1;
                        if (p == 1) begin
                            void'(mq[p].pop_front());
                            mq[p].push_back(r);
                        end
                    end
                end else if (pop) begin
                    void'(mq[p].pop_front());
                end
                if (cap) mseq[p] = mseq[p] + 8'd1;
            end
        end
    endtask

    task automatic check_all();
        mrec_t e;
        for (int p = 0; p < 2; p++) begin
            if (mq[p].size() != 0) e = mq[p][0];
            else                   e = '0;
            chk($sformatf("d%0d_valid", p), 64'(rv[p]), 64'(mq[p].size() != 0));
            chk($sformatf("d%0d_level", p), 64'(lvl[p]), 64'(mq[p].size()));
            chk($sformatf("d%0d_drop", p), 64'(drp[p]), 64'(mdrop[p]));
            chk($sformatf("d%0d_ovf", p), 64'(ovf[p]), 64'(movf[p]));
            chk($sformatf("d%0d_pc", p), 64'(rpc[p]), 64'(e.pc));
            chk($sformatf("d%0d_instr", p), 64'(rins[p]), 64'(e.instr));
            chk($sformatf("d%0d_kind", p), 64'(rknd[p]), 64'(e.kind));
            chk($sformatf("d%0d_rd", p), 64'(rrd[p]), 64'(e.rd));
            chk($sformatf("d%0d_data", p), 64'(rdat[p]), 64'(e.data));
            chk($sformatf("d%0d_addr", p), 64'(radr[p]), 64'(e.addr));
            chk($sformatf("d%0d_flags", p), 64'(rflg[p]), 64'(e.flags));
            chk($sformatf("d%0d_seq", p), 64'(rseq[p]), 64'(e.seq));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd,
                              input logic [31:0] rdat, input logic [31:0] madr, input logic [31:0] mdat);
        commit_valid_i = 1'b1;
        pc_i = pc; instr_i = ins; reg_addr_i = rd;
        reg_data_i = rdat; mem_addr_i = madr; mem_data_i = mdat;
    endtask

    task automatic apply_reset();
        rstn_i = 1'b0;
        #2;
        model_clear();
        check_all();
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    initial begin
        rstn_i = 1'b0; commit_valid_i = 1'b0; pc_i = '0; instr_i = '0; reg_addr_i = '0;
        reg_data_i = '0; mem_addr_i = '0; mem_data_i = '0; stall_i = 1'b0; flushD_i = 1'b0;
        flushE_i = 1'b0; filter_en_i = 1'b0; clear_i = 1'b0; rec_ready_i = 1'b1;
        model_clear();
        @(posedge clk_i);
        apply_reset();
        chk("rst_valid", 64'(rv[0]), 64'd0);

        // ADDI x5 visible one cycle after capture, then popped
        set_commit(32'h8000_0000, 32'h00A0_0293, 5'd5, 32'h0000_000A, 32'h0, 32'h0);
        step();
        chk("addi_kind", 64'(rknd[0]), 64'd1);
        chk("addi_data", 64'(rdat[0]), 64'h0A);
        chk("addi_seq", 64'(rseq[0]), 64'd0);
        commit_valid_i = 1'b0;
        step();
        chk("addi_popped", 64'(lvl[0]), 64'd0);

        // SB then SH (the SH pushes while the SB is popped)
        rec_ready_i = 1'b0;
        set_commit(32'h8000_0004, 32'h0051_0023, 5'd0, 32'h0, 32'h0000_0100, 32'h1234_5678);
        step();
        chk("sb_kind", 64'(rknd[1]), 64'd3);
        chk("sb_data", 64'(rdat[1]), 64'h78);
        chk("sb_addr", 64'(radr[1]), 64'h100);
        rec_ready_i = 1'b1;
        set_commit(32'h8000_0008, 32'h0051_1023, 5'd0, 32'h0, 32'h0000_0100, 32'h1234_5678);
        step();
        chk("sh_kind", 64'(rknd[0]), 64'd4);
        chk("sh_data", 64'(rdat[0]), 64'h5678);
        commit_valid_i = 1'b0;
        step();

        // Stall bubble, then the same bubble filtered out
        set_commit(32'h8000_000C, 32'h0000_0013, 5'd0, 32'h0, 32'h0, 32'h0);
        stall_i = 1'b1; rec_ready_i = 1'b0;
        step();
        chk("stall_kind", 64'(rknd[0]), 64'd6);
        chk("stall_flags", 64'(rflg[0]), 64'd1);
        rec_ready_i = 1'b1; filter_en_i = 1'b1;
        step();
        chk("filtered_level", 64'(lvl[0]), 64'd0);
        stall_i = 1'b0; filter_en_i = 1'b0;
        set_commit(32'h8000_0010, 32'h0010_0093, 5'd1, 32'h1, 32'h0, 32'h0);
        rec_ready_i = 1'b0;
        step();
        chk("seq_after_filter", 64'(rseq[0]), 64'd4);

        // Overflow: clear, then 10 commits into a stalled sink
        commit_valid_i = 1'b0; clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_commit(32'h9000_0000 + 32'(i * 4), 32'h0000_0013 | (32'(i % 31 + 1) << 7),
                       5'(i % 31 + 1), 32'(i), 32'h0, 32'h0);
            step();
        end
        chk("ovf_level", 64'(lvl[0]), 64'd8);
        chk("ovf_drop0", 64'(drp[0]), 64'd2);
        chk("ovf_drop1", 64'(drp[1]), 64'd2);
        chk("ovf_flag1", 64'(ovf[1]), 64'd1);
        commit_valid_i = 1'b0; rec_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_seq0", 64'(rseq[0]), 64'(i));
            chk("drain_seq1", 64'(rseq[1]), 64'(i + 2));
            step();
        end

        // Refill to full, then push with pop while full
        rec_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_commit(32'hA000_0000 + 32'(i * 4), 32'h0000_2003, 5'd3, 32'(i), 32'(i * 16), 32'h0);
            step();
        end
        rec_ready_i = 1'b1;
        step();
        chk("full_pushpop_level", 64'(lvl[1]), 64'd8);
        chk("full_pushpop_drop", 64'(drp[1]), 64'd2);

        // Clear wins over a concurrent push while full
        rec_ready_i = 1'b0;
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr_level", 64'(lvl[0]), 64'd0);
        chk("clr_drop", 64'(drp[0]), 64'd0);
        chk("clr_ovf", 64'(ovf[0]), 64'd0);
        chk("clr_valid", 64'(rv[1]), 64'd0);
        step();
        chk("clr_seq", 64'(rseq[0]), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            commit_valid_i = ($urandom_range(0, 9) < 7);
            pc_i = $urandom; reg_data_i = $urandom; mem_addr_i = $urandom; mem_data_i = $urandom;
            instr_i = $urandom;
            case ($urandom_range(0, 3))
                0: begin instr_i[6:0] = 7'b0100011; instr_i[14:12] = 3'($urandom_range(0, 3)); end
                1: instr_i[6:0] = 7'b0000011;
                2: instr_i[6:0] = 7'b0010011;
                default: ;
            endcase
            reg_addr_i  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            stall_i     = ($urandom_range(0, 3) == 0);
            flushD_i    = ($urandom_range(0, 5) == 0);
            flushE_i    = ($urandom_range(0, 5) == 0);
            filter_en_i = ($urandom_range(0, 3) == 0);
            clear_i     = ($urandom_range(0, 63) == 0);
            rec_ready_i = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            step();
            if (c == 350) apply_reset();
        end

        // Reset with records in flight
        commit_valid_i = 1'b1; clear_i = 1'b0; filter_en_i = 1'b0; rec_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        apply_reset();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
